ror_point_feeder: RTL and testbench

- Upstream stage of the ROR outlier Controller.
- Reads points from a single-port point RAM (x/y/z planes, 1-cycle read latency) and packs CORE_NUMBER core points into cache_x/y/z.
- Streams the whole cloud in M-point blocks into cache_feeder_x/y/z for the distance modules.
- Replaces the behavioural array feeding done in simulation with synthesizable fetch/pack logic.

---
 rtl/ror_point_feeder_if.sv | 54 +++++
 rtl/ror_point_feeder.sv | 217 +++++++++++++++++++++
 tb/tb_ror_point_feeder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ror_point_feeder_if.sv
// ror_point_feeder_if: bundles the controller handshake, point RAM read port,
// packed core-point cache and packed feeder block of the ROR point feeder.
interface ror_point_feeder_if #(
  parameter int N           = 16,
  parameter int M           = 4,
  parameter int CORE_NUMBER = 2
);
  logic                       start;
  logic [N-1:0]               point_cloud_size;
  logic [N-1:0]               point_pos;
  logic                       core_next;
  logic                       controller_done;

  logic [N-1:0]               mem_addr;
  logic                       mem_rd_en;
  logic [N-1:0]               mem_rdata_x;
  logic [N-1:0]               mem_rdata_y;
  logic [N-1:0]               mem_rdata_z;

  logic [N*CORE_NUMBER-1:0]   cache_x;
  logic [N*CORE_NUMBER-1:0]   cache_y;
  logic [N*CORE_NUMBER-1:0]   cache_z;
  logic [CORE_NUMBER-1:0]     cache_mask;
  logic                       cache_valid;

  logic [N*M-1:0]             cache_feeder_x;
  logic [N*M-1:0]             cache_feeder_y;
  logic [N*M-1:0]             cache_feeder_z;
  logic [M-1:0]               feeder_mask;
  logic [N-1:0]               feeder_base;
  logic                       feeder_valid;
  logic                       feeder_ready;
  logic                       sweep_done;

  // Feeder side: consumes controls and RAM data, produces addresses and packed points.
  modport master (
    input  start, point_cloud_size, point_pos, core_next, controller_done,
    input  mem_rdata_x, mem_rdata_y, mem_rdata_z, feeder_ready,
    output mem_addr, mem_rd_en,
    output cache_x, cache_y, cache_z, cache_mask, cache_valid,
    output cache_feeder_x, cache_feeder_y, cache_feeder_z,
    output feeder_mask, feeder_base, feeder_valid, sweep_done
  );

  // Controller / RAM / distance-module side.
  modport slave (
    output start, point_cloud_size, point_pos, core_next, controller_done,
    output mem_rdata_x, mem_rdata_y, mem_rdata_z, feeder_ready,
    input  mem_addr, mem_rd_en,
    input  cache_x, cache_y, cache_z, cache_mask, cache_valid,
    input  cache_feeder_x, cache_feeder_y, cache_feeder_z,
    input  feeder_mask, feeder_base, feeder_valid, sweep_done
  );
endinterface

// File: rtl/ror_point_feeder.sv
// ror_point_feeder: fetches CORE_NUMBER core points from the point RAM into the
// core cache, then streams the whole cloud in M-point blocks to the distance
// modules. Lane 0 sits in the MSBs and holds the lowest index.
// Optional macro FEEDER_STATS_EN adds sweep_count and busy_cycles outputs.
module ror_point_feeder #(
  parameter int N           = 16,
  parameter int M           = 4,
  parameter int CORE_NUMBER = 2
) (
  input  logic               clock,
  input  logic               reset,
  ror_point_feeder_if.master bus
`ifdef FEEDER_STATS_EN
  ,
  output logic [N-1:0]       sweep_count,
  output logic [31:0]        busy_cycles
`endif
);

  localparam int LMAX = (M > CORE_NUMBER) ? M : CORE_NUMBER;
  localparam int CW   = $clog2(LMAX + 1);
  localparam logic [CW-1:0] CORE_LAST = CW'(CORE_NUMBER);
  localparam logic [CW-1:0] FEED_LAST = CW'(M);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_FETCH,
    S_FEED_FETCH,
    S_FEED_HOLD,
    S_WAIT_CORE
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic [CW-1:0]            r_cnt;
  logic [N-1:0]             r_size;
  logic [N-1:0]             r_pos;
  logic [N:0]               r_base;
  logic [N*CORE_NUMBER-1:0] r_cacheX, r_cacheY, r_cacheZ;
  logic [CORE_NUMBER-1:0]   r_cacheMask;
  logic [N*M-1:0]           r_feedX, r_feedY, r_feedZ;
  logic [M-1:0]             r_feedMask;

  logic [N:0]               w_cntExt;
  logic [N:0]               w_origin;
  logic [N:0]               w_issueIdx;
  logic [N:0]               w_capIdx;
  logic [N:0]               w_nextBase;
  logic                     w_issueOk;
  logic                     w_capOk;
  logic                     w_lastBlock;
  logic [CW-1:0]            w_capLane;
  logic                     w_memRdEn;
  logic [N-1:0]             w_memAddr;
  logic                     w_sweepDone;

  // Index arithmetic carries one extra bit so base+M never wraps near 2^N.
  assign w_cntExt    = {{(N+1-CW){1'b0}}, r_cnt};
  assign w_origin    = (r_state == S_CORE_FETCH) ? {1'b0, r_pos} : r_base;
  assign w_issueIdx  = w_origin + w_cntExt;
  assign w_capIdx    = w_issueIdx - (N+1)'(1);
  assign w_issueOk   = (w_issueIdx < {1'b0, r_size});
  assign w_capOk     = (w_capIdx < {1'b0, r_size});
  assign w_capLane   = r_cnt - CW'(1);
  assign w_nextBase  = r_base + (N+1)'(M);
  assign w_lastBlock = (w_nextBase >= {1'b0, r_size});

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state, RAM read issue and sweep pulse; controller_done overrides everything.
  always_comb begin
    w_nextState = r_state;
    w_memRdEn   = 1'b0;
    w_memAddr   = '0;
    w_sweepDone = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.start) w_nextState = S_CORE_FETCH;
      S_CORE_FETCH: begin
        if (r_cnt < CORE_LAST) begin
          w_memRdEn = w_issueOk;
          w_memAddr = w_issueIdx[N-1:0];
        end else begin
          w_nextState = S_FEED_FETCH;
        end
      end
      S_FEED_FETCH: begin
        if (r_cnt < FEED_LAST) begin
          w_memRdEn = w_issueOk;
          w_memAddr = w_issueIdx[N-1:0];
        end else begin
          w_nextState = S_FEED_HOLD;
        end
      end
      S_FEED_HOLD: begin
        if (bus.feeder_ready) begin
          if (w_lastBlock) begin
            w_sweepDone = 1'b1;
            w_nextState = S_WAIT_CORE;
          end else begin
            w_nextState = S_FEED_FETCH;
          end
        end
      end
      S_WAIT_CORE: if (bus.core_next) w_nextState = S_CORE_FETCH;
      default: w_nextState = S_IDLE;
    endcase
    if (bus.controller_done) begin
      w_nextState = S_IDLE;
      w_sweepDone = 1'b0;
    end
  end

  // Counters, latched size/position/base, and lane capture one cycle after each read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_size      <= '0;
      r_pos       <= '0;
      r_base      <= '0;
      r_cacheX    <= '0;
      r_cacheY    <= '0;
      r_cacheZ    <= '0;
      r_cacheMask <= '0;
      r_feedX     <= '0;
      r_feedY     <= '0;
      r_feedZ     <= '0;
      r_feedMask  <= '0;
    end else begin
      if (w_nextState != r_state)
        r_cnt <= '0;
      else if (r_state == S_CORE_FETCH || r_state == S_FEED_FETCH)
        r_cnt <= r_cnt + 1'b1;

      if (r_state == S_IDLE && w_nextState == S_CORE_FETCH)
        r_size <= bus.point_cloud_size;
      if (r_state != S_CORE_FETCH && w_nextState == S_CORE_FETCH)
        r_pos <= bus.point_pos;

      if (r_state == S_IDLE && w_nextState == S_CORE_FETCH)
        r_base <= '0;
      else if (r_state == S_CORE_FETCH && w_nextState == S_FEED_FETCH)
        r_base <= '0;
      else if (r_state == S_FEED_HOLD && w_nextState == S_FEED_FETCH)
        r_base <= w_nextBase;
      else if (w_sweepDone)
        r_base <= '0;

      if (r_state == S_CORE_FETCH && r_cnt != '0) begin
        for (int k = 0; k < CORE_NUMBER; k++) begin
          if (w_capLane == CW'(k)) begin
            r_cacheX[N*(CORE_NUMBER-k)-1 -: N] <= w_capOk ? bus.mem_rdata_x : '0;
            r_cacheY[N*(CORE_NUMBER-k)-1 -: N] <= w_capOk ? bus.mem_rdata_y : '0;
            r_cacheZ[N*(CORE_NUMBER-k)-1 -: N] <= w_capOk ? bus.mem_rdata_z : '0;
            r_cacheMask[CORE_NUMBER-1-k]       <= w_capOk;
          end
        end
      end

      if (r_state == S_FEED_FETCH && r_cnt != '0) begin
        for (int k = 0; k < M; k++) begin
          if (w_capLane == CW'(k)) begin
            r_feedX[N*(M-k)-1 -: N] <= w_capOk ? bus.mem_rdata_x : '0;
            r_feedY[N*(M-k)-1 -: N] <= w_capOk ? bus.mem_rdata_y : '0;
            r_feedZ[N*(M-k)-1 -: N] <= w_capOk ? bus.mem_rdata_z : '0;
            r_feedMask[M-1-k]       <= w_capOk;
          end
        end
      end
    end
  end

  assign bus.mem_addr       = w_memAddr;
  assign bus.mem_rd_en      = w_memRdEn;
  assign bus.cache_x        = r_cacheX;
  assign bus.cache_y        = r_cacheY;
  assign bus.cache_z        = r_cacheZ;
  assign bus.cache_mask     = r_cacheMask;
  assign bus.cache_valid    = (r_state == S_FEED_FETCH) || (r_state == S_FEED_HOLD) ||
                              (r_state == S_WAIT_CORE);
  assign bus.cache_feeder_x = r_feedX;
  assign bus.cache_feeder_y = r_feedY;
  assign bus.cache_feeder_z = r_feedZ;
  assign bus.feeder_mask    = r_feedMask;
  assign bus.feeder_base    = r_base[N-1:0];
  assign bus.feeder_valid   = (r_state == S_FEED_HOLD);
  assign bus.sweep_done     = w_sweepDone;

`ifdef FEEDER_STATS_EN
  logic [N-1:0] r_sweepCount;
  logic [31:0]  r_busyCycles;

  // Sweep count restarts with each run; busy count saturates rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sweepCount <= '0;
      r_busyCycles <= '0;
    end else begin
      if (r_state == S_IDLE && w_nextState == S_CORE_FETCH)
        r_sweepCount <= '0;
      else if (w_sweepDone)
        r_sweepCount <= r_sweepCount + 1'b1;
      if (r_state != S_IDLE && r_busyCycles != 32'hFFFF_FFFF)
        r_busyCycles <= r_busyCycles + 1'b1;
    end
  end

  assign sweep_count = r_sweepCount;
  assign busy_cycles = r_busyCycles;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_ror_point_feeder.sv
// tb_ror_point_feeder: directed test of ror_point_feeder with a RAM model
// holding x[i]=i, y[i]=0x100+i, z[i]=0x200+i.
module tb_ror_point_feeder;
  localparam int N  = 16;
  localparam int M  = 4;
  localparam int CN = 2;

  logic         clock = 1'b0;
  logic         reset;
  int           compared   = 0;
  int           mismatched = 0;
  int           badReads   = 0;
  int           holdReads  = 0;
  logic [N-1:0] tbSize     = '1;

  ror_point_feeder_if #(.N(N), .M(M), .CORE_NUMBER(CN)) bus ();

`ifdef FEEDER_STATS_EN
  logic [N-1:0] sweepCount;
  logic [31:0]  busyCycles;
`endif

  ror_point_feeder #(.N(N), .M(M), .CORE_NUMBER(CN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef FEEDER_STATS_EN
    ,
    .sweep_count (sweepCount),
    .busy_cycles (busyCycles)
`endif
  );

  always #5 clock = ~clock;

  // Point RAM model with one cycle of read latency.
  always @(posedge clock) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata_x <= bus.mem_addr;
      bus.mem_rdata_y <= bus.mem_addr + 16'h0100;
      bus.mem_rdata_z <= bus.mem_addr + 16'h0200;
    end
  end

  // Any read at or beyond the cloud size is illegal.
  always @(negedge clock) begin
    if (!reset && bus.mem_rd_en && bus.mem_addr >= tbSize) badReads++;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle pulse of the controller inputs.
  task automatic applyStimulus(input logic s, input logic c, input logic d,
                               input logic [N-1:0] pos, input logic [N-1:0] size);
    @(posedge clock); #1;
    bus.start            = s;
    bus.core_next        = c;
    bus.controller_done  = d;
    bus.point_pos        = pos;
    bus.point_cloud_size = size;
    @(posedge clock); #1;
    bus.start           = 1'b0;
    bus.core_next       = 1'b0;
    bus.controller_done = 1'b0;
  endtask

  task automatic waitFeederValid(input string tag);
    int n = 0;
    @(negedge clock);
    while (!bus.feeder_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, bus.feeder_valid, 1);
  endtask

  task automatic acceptBlock(input string tag, input logic expSweep);
    @(posedge clock); #1;
    bus.feeder_ready = 1'b1;
    @(negedge clock);
    checkOutput(tag, bus.sweep_done, expSweep);
    @(posedge clock); #1;
    bus.feeder_ready = 1'b0;
  endtask

  task automatic checkBlock(input string tag, input logic [63:0] expX,
                            input logic [3:0] expMask, input logic [N-1:0] expBase);
    checkOutput({tag, "_x"}, bus.cache_feeder_x, expX);
    checkOutput({tag, "_mask"}, bus.feeder_mask, expMask);
    checkOutput({tag, "_base"}, bus.feeder_base, expBase);
  endtask

  initial begin
    reset                = 1'b1;
    bus.start            = 1'b0;
    bus.core_next        = 1'b0;
    bus.controller_done  = 1'b0;
    bus.point_pos        = '0;
    bus.point_cloud_size = '0;
    bus.feeder_ready     = 1'b0;
    bus.mem_rdata_x      = '0;
    bus.mem_rdata_y      = '0;
    bus.mem_rdata_z      = '0;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_cache_valid", bus.cache_valid, 0);
    checkOutput("rst_feeder_valid", bus.feeder_valid, 0);
    checkOutput("rst_mem_rd_en", bus.mem_rd_en, 0);
    checkOutput("rst_sweep_done", bus.sweep_done, 0);
    checkOutput("rst_cache_x", bus.cache_x, 0);
    checkOutput("rst_feeder_x", bus.cache_feeder_x, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Reset asserted in the middle of a feeder fetch.
    tbSize = 16'd10;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd10);
    repeat (4) @(posedge clock);
    @(negedge clock);
    checkOutput("midrst_pre_cache_valid", bus.cache_valid, 1);
    checkOutput("midrst_pre_feeder_valid", bus.feeder_valid, 0);
    checkOutput("midrst_pre_cache_x", bus.cache_x, 64'h0000_0001);
    reset = 1'b1;
    #1;
    checkOutput("midrst_cache_x", bus.cache_x, 0);
    checkOutput("midrst_cache_mask", bus.cache_mask, 0);
    checkOutput("midrst_cache_valid", bus.cache_valid, 0);
    checkOutput("midrst_mem_rd_en", bus.mem_rd_en, 0);
    checkOutput("midrst_feeder_mask", bus.feeder_mask, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Full sweep over 10 points from point_pos 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd10);
    waitFeederValid("blk0_valid");
    checkOutput("core0_x", bus.cache_x, 64'h0000_0001);
    checkOutput("core0_y", bus.cache_y, 64'h0100_0101);
    checkOutput("core0_z", bus.cache_z, 64'h0200_0201);
    checkOutput("core0_mask", bus.cache_mask, 2'b11);
    checkOutput("core0_valid", bus.cache_valid, 1);
    checkBlock("blk0", 64'h0000_0001_0002_0003, 4'b1111, 16'd0);
    checkOutput("blk0_y", bus.cache_feeder_y, 64'h0100_0101_0102_0103);
    checkOutput("blk0_z", bus.cache_feeder_z, 64'h0200_0201_0202_0203);
    checkOutput("blk0_sweep_idle", bus.sweep_done, 0);

    // Backpressure: five cycles with feeder_ready low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus.mem_rd_en) holdReads++;
    end
    checkOutput("hold_no_reads", holdReads, 0);
    checkOutput("hold_valid", bus.feeder_valid, 1);
    checkBlock("hold", 64'h0000_0001_0002_0003, 4'b1111, 16'd0);

    acceptBlock("blk0_accept_sweep", 1'b0);
    waitFeederValid("blk1_valid");
    checkBlock("blk1", 64'h0004_0005_0006_0007, 4'b1111, 16'd4);
    acceptBlock("blk1_accept_sweep", 1'b0);
    waitFeederValid("blk2_valid");
    checkBlock("blk2", 64'h0008_0009_0000_0000, 4'b1100, 16'd8);
    acceptBlock("blk2_accept_sweep", 1'b1);
    @(negedge clock);
    checkOutput("wait_feeder_valid", bus.feeder_valid, 0);
    checkOutput("wait_sweep_done", bus.sweep_done, 0);
    checkOutput("wait_cache_valid", bus.cache_valid, 1);
    checkOutput("wait_cache_x", bus.cache_x, 64'h0000_0001);
    checkOutput("wait_feeder_base", bus.feeder_base, 0);
`ifdef FEEDER_STATS_EN
    checkOutput("stats_sweep_count", sweepCount, 1);
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("wait_idle_rd_en", bus.mem_rd_en, 0);
    checkOutput("wait_still_cache_valid", bus.cache_valid, 1);

    // start is ignored outside IDLE; then a core group at the tail of the cloud.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd9, 16'd3);
    waitFeederValid("tail_valid");
    checkOutput("tail_cache_x", bus.cache_x, 64'h0009_0000);
    checkOutput("tail_cache_y", bus.cache_y, 64'h0109_0000);
    checkOutput("tail_cache_mask", bus.cache_mask, 2'b10);
    checkBlock("tail_blk0", 64'h0000_0001_0002_0003, 4'b1111, 16'd0);
    acceptBlock("tail_blk0_sweep", 1'b0);
    waitFeederValid("tail_blk1_valid");
    checkOutput("tail_blk1_base", bus.feeder_base, 16'd4);

    // core_next is ignored outside WAIT_CORE.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd5, 16'd3);
    @(negedge clock);
    checkOutput("ign_core_next_valid", bus.feeder_valid, 1);
    checkOutput("ign_core_next_cache_x", bus.cache_x, 64'h0009_0000);
    checkOutput("ign_core_next_base", bus.feeder_base, 16'd4);

    // controller_done in FEED_HOLD returns to IDLE; data outputs stay put.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd5, 16'd3);
    @(negedge clock);
    checkOutput("done_feeder_valid", bus.feeder_valid, 0);
    checkOutput("done_cache_valid", bus.cache_valid, 0);
    checkOutput("done_mem_rd_en", bus.mem_rd_en, 0);
    checkOutput("done_feeder_x_kept", bus.cache_feeder_x, 64'h0004_0005_0006_0007);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd2, 16'd10);
    waitFeederValid("restart_valid");
    checkOutput("restart_cache_x", bus.cache_x, 64'h0002_0003);
    checkBlock("restart_blk0", 64'h0000_0001_0002_0003, 4'b1111, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd2, 16'd10);

    // Empty cloud: masked core group, one masked block, then sweep_done.
    @(negedge clock);
    tbSize = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    waitFeederValid("size0_valid");
    checkOutput("size0_cache_mask", bus.cache_mask, 0);
    checkOutput("size0_cache_x", bus.cache_x, 0);
    checkBlock("size0_blk", 64'h0, 4'b0000, 16'd0);
    acceptBlock("size0_sweep", 1'b1);
    @(negedge clock);
    checkOutput("size0_after_valid", bus.feeder_valid, 0);

    checkOutput("no_out_of_range_read", badReads, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
